// File: rtl/obj_wr_sched_pkg.sv
// obj_wr_sched_pkg: shared widths, object addresses and state encodings for the object write scheduler
package obj_wr_sched_pkg;
  localparam int OBJ_ADDR_W = 3;
  localparam int OBJ_DATA_W = 10;
  localparam int PAD_W = 9;
  localparam int FIFO_DEPTH = 4;
  localparam int ENTRY_W = OBJ_ADDR_W + OBJ_DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OBJ_ADDR_W-1:0] PAD1_ADDR = 3'd0;
  localparam logic [OBJ_ADDR_W-1:0] PAD2_ADDR = 3'd1;
  typedef enum logic {IDLE, COMMIT} state_e;
  typedef enum logic {SRC_CPU, SRC_PAD} src_e;
  typedef struct packed {
    logic [OBJ_ADDR_W-1:0] addr;
    logic [OBJ_DATA_W-1:0] data;
  } obj_wr_t;
  function automatic logic [OBJ_DATA_W-1:0] pad_ext(input logic [PAD_W-1:0] p);
    return {{(OBJ_DATA_W-PAD_W){1'b0}}, p};
  endfunction
endpackage

// File: rtl/obj_wr_fifo.sv
// obj_wr_fifo: small synchronous FIFO buffering CPU object writes; push while full is accepted only with a same-cycle pop
module obj_wr_fifo #(
  parameter int W = 13,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= din_i;
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: rtl/obj_wr_sched.sv
// obj_wr_sched: commits buffered CPU object writes and dirty paddle positions to vgadisplay only during vblank
module obj_wr_sched
  import obj_wr_sched_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_sel_i,
  input  logic                  cpu_we_i,
  input  logic [OBJ_ADDR_W-1:0] cpu_addr_i,
  input  logic [OBJ_DATA_W-1:0] cpu_data_i,
  input  logic                  ovf_clr_i,
  input  logic [PAD_W-1:0]      paddle1_i,
  input  logic [PAD_W-1:0]      paddle2_i,
  input  logic                  vblank_i,
  output logic                  obj_we_o,
  output logic [OBJ_ADDR_W-1:0] obj_addr_o,
  output logic [OBJ_DATA_W-1:0] obj_data_o,
  output logic                  fifo_full_o,
  output logic                  ovf_o
);
  state_e state_q, state_d;
  src_e rr_q, rr_d;
  logic vb_q, ovf_q, ovf_d, obj_we_q, obj_we_d;
  logic dirty1_q, dirty1_d, dirty2_q, dirty2_d;
  logic [PAD_W-1:0] last_p1_q, last_p1_d, last_p2_q, last_p2_d;
  obj_wr_t obj_q, obj_d, fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic fifo_full, fifo_empty;
  logic push_req, push_ok, active, pad_pend, gnt_cpu, gnt_pad, gnt_p1, gnt_p2;

  obj_wr_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH), .CW(CNT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .pop_i   (gnt_cpu),
    .din_i   ({cpu_addr_i, cpu_data_i}),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign push_req = cpu_sel_i & cpu_we_i;
  assign push_ok = push_req & (~fifo_full | gnt_cpu);
  // Grants stop the same cycle vblank falls; pending work simply waits for the next window.
  assign active = (state_q == COMMIT) & vblank_i;
  assign pad_pend = dirty1_q | dirty2_q;
  assign gnt_cpu = active & ~fifo_empty & ((rr_q == SRC_CPU) | ~pad_pend);
  assign gnt_pad = active & pad_pend & ~gnt_cpu;
  assign gnt_p1 = gnt_pad & dirty1_q;
  assign gnt_p2 = gnt_pad & ~dirty1_q;

  always_comb begin
    state_d = (state_q == IDLE) ? ((vblank_i & ~vb_q) ? COMMIT : IDLE)
                                : ((~vblank_i | (fifo_empty & ~pad_pend)) ? IDLE : COMMIT);
    rr_d = gnt_cpu ? SRC_PAD : gnt_pad ? SRC_CPU : rr_q;
    dirty1_d = ~gnt_p1 & (dirty1_q | (paddle1_i != last_p1_q));
    dirty2_d = ~gnt_p2 & (dirty2_q | (paddle2_i != last_p2_q));
    last_p1_d = gnt_p1 ? paddle1_i : last_p1_q;
    last_p2_d = gnt_p2 ? paddle2_i : last_p2_q;
    ovf_d = (push_req & ~push_ok) | (ovf_q & ~ovf_clr_i);
    obj_we_d = gnt_cpu | gnt_pad;
    obj_d = gnt_cpu ? fifo_dout
          : gnt_p1  ? {PAD1_ADDR, pad_ext(paddle1_i)}
          : gnt_p2  ? {PAD2_ADDR, pad_ext(paddle2_i)}
          : obj_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q <= SRC_CPU;
      vb_q <= 1'b0;
      ovf_q <= 1'b0;
      dirty1_q <= 1'b1;
      dirty2_q <= 1'b1;
      last_p1_q <= '0;
      last_p2_q <= '0;
      obj_we_q <= 1'b0;
      obj_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      vb_q <= vblank_i;
      ovf_q <= ovf_d;
      dirty1_q <= dirty1_d;
      dirty2_q <= dirty2_d;
      last_p1_q <= last_p1_d;
      last_p2_q <= last_p2_d;
      obj_we_q <= obj_we_d;
      obj_q <= obj_d;
    end
  end

  assign obj_we_o = obj_we_q;
  assign obj_addr_o = obj_q.addr;
  assign obj_data_o = obj_q.data;
  assign fifo_full_o = fifo_count == CNT_W'(FIFO_DEPTH);
  assign ovf_o = ovf_q;
endmodule
